// File: rtl/difficulty_check.sv
// Streams a hash MSW-first and checks that it has at least `difficulty`
// leading zero bits; reports the verdict with a one-cycle done pulse.
module difficulty_check #(
  parameter int HASH_WIDTH = 256,
  parameter int WORD_WIDTH = 16,
  parameter int DIFF_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIFF_WIDTH-1:0] difficulty,
  input  logic [WORD_WIDTH-1:0] hash_word,
  input  logic                  hash_valid,
  output logic                  hash_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  success
);

  localparam int NUM_WORDS = HASH_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [DIFF_WIDTH-1:0] MAX_D = DIFF_WIDTH'(HASH_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]      idx;
  logic [DIFF_WIDTH-1:0] d;
  logic                  fail;
  logic                  accept;
  logic                  last;
  logic                  hit;
  logic [DIFF_WIDTH:0]   base;
  logic [WORD_WIDTH-1:0] mask;

  assign accept = hash_valid && (state == CHECK);
  assign last   = (idx == LAST_IDX);
  assign hit    = |(hash_word & mask);

  // Bit j of word idx sits at absolute position idx*W + (W-1-j) from the MSB.
  always_comb begin
    mask = '0;
    base = (DIFF_WIDTH+1)'(idx) * (DIFF_WIDTH+1)'(WORD_WIDTH);
    for (int j = 0; j < WORD_WIDTH; j++) begin
      if ((base + (DIFF_WIDTH+1)'(WORD_WIDTH - 1 - j)) < {1'b0, d})
        mask[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    hash_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CHECK;
      end
      CHECK: begin
        hash_ready = 1'b1;
        busy       = 1'b1;
        if (hash_valid && last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      d       <= '0;
      fail    <= 1'b0;
      success <= 1'b0;
    end else if (state == IDLE && start) begin
      idx     <= '0;
      d       <= (difficulty > MAX_D) ? MAX_D : difficulty;
      fail    <= 1'b0;
      success <= 1'b0;
    end else if (accept) begin
      idx  <= idx + 1'b1;
      fail <= fail | hit;
      // Verdict is registered so it is valid alongside done.
      if (last) success <= ~(fail | hit);
    end
  end

endmodule

// File: tb/tb_difficulty_check.sv
// Randomized self-checking bench for difficulty_check against a
// leading-zero-count reference model.
module tb_difficulty_check;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  difficulty;
  logic [15:0] hash_word;
  logic        hash_valid;
  logic        hash_ready;
  logic        busy;
  logic        done;
  logic        success;

  int checks;
  int errors;

  difficulty_check #(
    .HASH_WIDTH(256),
    .WORD_WIDTH(16),
    .DIFF_WIDTH(9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .difficulty(difficulty),
    .hash_word (hash_word),
    .hash_valid(hash_valid),
    .hash_ready(hash_ready),
    .busy      (busy),
    .done      (done),
    .success   (success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model(input logic [8:0] diff,
                               input logic [255:0] h);
    int lz;
    int dc;
    lz = 0;
    while (lz < 256 && !h[255 - lz]) lz++;
    dc = (int'(diff) > 256) ? 256 : int'(diff);
    return lz >= dc;
  endfunction

  function automatic logic [255:0] make_hash(input int lz);
    logic [255:0] h;
    for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom();
    for (int b = 0; b < 256; b++)
      if (b > 255 - lz) h[b] = 1'b0;
    if (lz < 256) h[255 - lz] = 1'b1;
    return h;
  endfunction

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      hash_valid = 1'b1;
      hash_word  = 16'($urandom());
      @(posedge clk); #1;
      check("idle_ready", hash_ready, 0);
    end
    hash_valid = 1'b0;
  endtask

  task automatic run(input logic [8:0] diff, input logic [255:0] h,
                     input bit gaps, input bit stray);
    bit exp;
    int lat;
    int i;
    bit early;
    exp = model(diff, h);
    @(posedge clk); #1;
    start = 1'b1;
    difficulty = diff;
    hash_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("busy", busy, 1);
    check("ready", hash_ready, 1);
    check("succ_clr", success, 0);
    i = 0;
    early = 1'b0;
    while (i < 16 && lat < 400) begin
      hash_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      hash_word  = hash_valid ? h[255 - 16*i -: 16] : 16'($urandom());
      if (stray && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        difficulty = 9'($urandom());
      end else begin
        start = 1'b0;
      end
      if (hash_valid) i++;
      @(posedge clk); #1;
      lat++;
      if (i < 16 && done) early = 1'b1;
    end
    hash_valid = 1'b0;
    start = 1'b0;
    check("timeout", i, 16);
    check("early_done", early, 0);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("success", success, exp);
    if (!gaps) check("latency", lat, 17);
    if (stray) begin
      start = 1'b1;
      difficulty = 9'd0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("held", success, exp);
    if (stray) check("done_start_ign", busy, 0);
  endtask

  task automatic run_reset_mid;
    bit saw;
    @(posedge clk); #1;
    start = 1'b1;
    difficulty = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hash_valid = 1'b1;
      hash_word  = 16'($urandom());
      @(posedge clk); #1;
    end
    hash_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", hash_ready, 0);
    check("rst_done", done, 0);
    check("rst_succ", success, 0);
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("rst_no_done", saw, 0);
  endtask

  logic [255:0] h;
  logic [255:0] ones;
  int lz;
  int dv;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    difficulty = '0;
    hash_word = '0;
    hash_valid = 1'b0;
    ones = '1;
    #2;
    reset = 1'b1;
    #1;
    check("rst_state_busy", busy, 0);
    check("rst_state_ready", hash_ready, 0);
    check("rst_state_done", done, 0);
    check("rst_state_succ", success, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run(9'd0, ones, 1'b0, 1'b0);

    h = ones;
    h[255 -: 16] = 16'h0FFF;
    run(9'd4, h, 1'b0, 1'b0);
    h[255 -: 16] = 16'h1FFF;
    run(9'd4, h, 1'b0, 1'b0);

    h = ones;
    h[255 -: 16] = 16'h0000;
    h[239 -: 16] = 16'h0FFF;
    run(9'd20, h, 1'b0, 1'b0);
    h[239 -: 16] = 16'h1000;
    run(9'd20, h, 1'b0, 1'b0);

    h = '0;
    run(9'd300, h, 1'b0, 1'b0);
    run(9'd256, h, 1'b0, 1'b0);
    h[15:0] = 16'h0001;
    run(9'd300, h, 1'b0, 1'b0);
    run(9'd255, h, 1'b0, 1'b0);

    #2;
    reset = 1'b1;
    #1;
    check("rst_idle_succ", success, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    idle_noise(3);
    h = make_hash(37);
    run(9'd37, h, 1'b0, 1'b0);
    run(9'd37, h, 1'b1, 1'b1);
    run(9'd38, h, 1'b1, 1'b1);

    run_reset_mid();
    h = make_hash(16);
    run(9'd16, h, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      lz = $urandom_range(0, 256);
      h  = make_hash(lz);
      if (t % 6 == 5) dv = $urandom_range(250, 511);
      else dv = lz + $urandom_range(0, 4) - 2;
      if (dv < 0) dv = 0;
      run(9'(dv), h, t[0], t[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
